// File: rtl/hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module : hazard_ctrl                                                |
// | Desc   : RV32I 5-stage hazard controller: load-use / jalr stalls,   |
// |          taken-branch flush and EX operand forwarding selects.      |
// |          Optional perf counters enabled by macro HAZARD_PERF_EN.    |
// | Rev    : 1.0  initial release                                       |
// +---------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int RFIDX_WIDTH  = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef HAZARD_PERF_EN
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt,
`endif
  input  logic                   id_valid,
  input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
  input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] id_rd_index,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_jalr_en,
  input  logic                   ex_bxx_taken,
  output logic                   pc_stall,
  output logic                   idex_bubble,
  output logic                   bxx_flush,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel
);

  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_INIT = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
  localparam logic [0:0] c_ST_RUN   = 1'b0;
  localparam logic [0:0] c_ST_FLUSH = 1'b1;

  logic [0:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;

  logic                   r_ex_v, r_ex_wr, r_ex_ld, r_ex_rs1_used, r_ex_rs2_used;
  logic [RFIDX_WIDTH-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic                   r_mem_v, r_mem_wr, r_mem_ld;
  logic [RFIDX_WIDTH-1:0] r_mem_rd;
  logic                   r_wb_v, r_wb_wr;
  logic [RFIDX_WIDTH-1:0] r_wb_rd;

  logic w_ld_use, w_jalr_haz, w_cause, w_issue;

  // x0 is hard-wired zero, so it never produces a dependency.
  function automatic logic hit(input logic v, input logic wr,
                               input logic [RFIDX_WIDTH-1:0] rd,
                               input logic [RFIDX_WIDTH-1:0] idx);
    return v & wr & (rd != '0) & (rd == idx);
  endfunction

  assign w_ld_use   = id_valid & r_ex_ld &
                      ((id_rs1_used & hit(r_ex_v, r_ex_wr, r_ex_rd, id_rs1_index)) |
                       (id_rs2_used & hit(r_ex_v, r_ex_wr, r_ex_rd, id_rs2_index)));
  assign w_jalr_haz = id_valid & id_jalr_en &
                      (hit(r_ex_v, r_ex_wr, r_ex_rd, id_rs1_index) |
                       hit(r_mem_v, r_mem_wr, r_mem_rd, id_rs1_index));
  assign w_cause    = w_ld_use | w_jalr_haz;

  assign bxx_flush   = (r_state == c_ST_FLUSH) | ex_bxx_taken;
  assign pc_stall    = w_cause & ~bxx_flush;
  assign idex_bubble = w_cause | bxx_flush;
  assign w_issue     = id_valid & ~pc_stall & ~bxx_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_RUN;
      r_cnt   <= '0;
    end else if (r_state == c_ST_RUN) begin
      if (ex_bxx_taken && (FLUSH_CYCLES > 1)) begin
        r_state <= c_ST_FLUSH;
        r_cnt   <= c_CNT_INIT;
      end
    end else begin
      if (r_cnt == '0) r_state <= c_ST_RUN;
      else             r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v <= 1'b0; r_ex_wr <= 1'b0; r_ex_ld <= 1'b0;
      r_ex_rs1_used <= 1'b0; r_ex_rs2_used <= 1'b0;
      r_ex_rd <= '0; r_ex_rs1 <= '0; r_ex_rs2 <= '0;
      r_mem_v <= 1'b0; r_mem_wr <= 1'b0; r_mem_ld <= 1'b0; r_mem_rd <= '0;
      r_wb_v  <= 1'b0; r_wb_wr  <= 1'b0; r_wb_rd  <= '0;
    end else begin
      r_wb_v   <= r_mem_v;  r_wb_wr  <= r_mem_wr; r_wb_rd <= r_mem_rd;
      r_mem_v  <= r_ex_v;   r_mem_wr <= r_ex_wr;  r_mem_ld <= r_ex_ld; r_mem_rd <= r_ex_rd;
      r_ex_v        <= w_issue;
      r_ex_wr       <= id_reg_write;
      r_ex_ld       <= id_mem_read;
      r_ex_rd       <= id_rd_index;
      r_ex_rs1      <= id_rs1_index;
      r_ex_rs2      <= id_rs2_index;
      r_ex_rs1_used <= id_rs1_used;
      r_ex_rs2_used <= id_rs2_used;
    end
  end

  // A load in MEM never feeds EX directly; the load-use stall spaces it into WB.
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (r_ex_v && r_ex_rs1_used) begin
      if (hit(r_mem_v & ~r_mem_ld, r_mem_wr, r_mem_rd, r_ex_rs1)) fwd_a_sel = 2'd1;
      else if (hit(r_wb_v, r_wb_wr, r_wb_rd, r_ex_rs1))           fwd_a_sel = 2'd2;
    end
    if (r_ex_v && r_ex_rs2_used) begin
      if (hit(r_mem_v & ~r_mem_ld, r_mem_wr, r_mem_rd, r_ex_rs2)) fwd_b_sel = 2'd1;
      else if (hit(r_wb_v, r_wb_wr, r_wb_rd, r_ex_rs2))           fwd_b_sel = 2'd2;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall  && (perf_stall_cnt != 32'hFFFF_FFFF)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bxx_flush && (perf_flush_cnt != 32'hFFFF_FFFF)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | Module : tb_hazard_ctrl                                             |
// | Desc   : Directed + random self-checking bench for hazard_ctrl.     |
// | Rev    : 1.0  initial release                                       |
// +---------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_jalr_en, ex_bxx_taken;
  logic [4:0] id_rs1_index, id_rs2_index, id_rd_index;
  logic       pc_stall, idex_bubble, bxx_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.RFIDX_WIDTH(5), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .id_valid(id_valid), .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_index(id_rd_index),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jalr_en(id_jalr_en),
    .ex_bxx_taken(ex_bxx_taken), .pc_stall(pc_stall), .idex_bubble(idex_bubble),
    .bxx_flush(bxx_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  // Reference model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic v; logic [4:0] rd; logic wr; logic ld;
    logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
  } ins_t;

  ins_t m_pipe [3];
  int   m_flush_left;
  int   m_stalls, m_flushes;
  int   n_cmp = 0, n_err = 0;
  logic o_stall, o_bub, o_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input ins_t s, input logic [4:0] r);
    return s.v && s.wr && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r, input logic used);
    if (!m_pipe[0].v || !used) return 2'd0;
    if (writes(m_pipe[1], r) && !m_pipe[1].ld) return 2'd1;
    if (writes(m_pipe[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_flush_left = 0;
    m_stalls     = 0;
    m_flushes    = 0;
  endtask

  task automatic step(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic jalr, input logic taken);
    ins_t n;
    bit e_flush, ldu, jh, e_stall;
    id_valid = vld; id_rs1_index = rs1; id_rs2_index = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd_index = rd; id_reg_write = wr; id_mem_read = ld; id_jalr_en = jalr; ex_bxx_taken = taken;
    #2;
    e_flush = (m_flush_left > 0) || taken;
    ldu     = vld && m_pipe[0].ld && ((u1 && writes(m_pipe[0], rs1)) || (u2 && writes(m_pipe[0], rs2)));
    jh      = vld && jalr && (writes(m_pipe[0], rs1) || writes(m_pipe[1], rs1));
    e_stall = (ldu || jh) && !e_flush;
    o_stall = pc_stall; o_bub = idex_bubble; o_flush = bxx_flush;
    chk("pc_stall",    pc_stall,    32'(e_stall));
    chk("idex_bubble", idex_bubble, 32'(ldu || jh || e_flush));
    chk("bxx_flush",   bxx_flush,   32'(e_flush));
    chk("fwd_a_sel",   fwd_a_sel,   32'(exp_fwd(m_pipe[0].rs1, m_pipe[0].u1)));
    chk("fwd_b_sel",   fwd_b_sel,   32'(exp_fwd(m_pipe[0].rs2, m_pipe[0].u2)));
    @(posedge clk);
    n = '{v: vld && !e_stall && !e_flush, rd: rd, wr: wr, ld: ld, rs1: rs1, rs2: rs2, u1: u1, u2: u2};
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = n;
    if (m_flush_left > 0) m_flush_left--;
    else if (taken)       m_flush_left = FC - 1;
    if (e_stall) m_stalls++;
    if (e_flush) m_flushes++;
    #1;
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stalls));
    chk("perf_flush_cnt", perf_flush_cnt, 32'(m_flushes));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1_index = 0; id_rs2_index = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd_index = 0; id_reg_write = 0; id_mem_read = 0; id_jalr_en = 0; ex_bxx_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_bubble",   idex_bubble, 0);
    chk("rst_flush",    bxx_flush, 0);
    chk("rst_fwd_a",    fwd_a_sel, 0);
    chk("rst_fwd_b",    fwd_b_sel, 0);
    rst_n = 1'b1;

    // lw x5 ; add x6,x5,x1 -> one stall, then WB forward
    step(1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("lu_stall", o_stall, 1);
    chk("lu_bubble", o_bub, 1);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("lu_issue", o_stall, 0);
    chk("lu_fwd_a_wb", fwd_a_sel, 2);

    // addi x7 ; jalr x0,0(x7) -> stalls while x7 in EX then MEM
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step(1, 7, 0, 1, 0, 0, 1, 0, 1, 0);
    chk("jalr_stall1", o_stall, 1);
    step(1, 7, 0, 1, 0, 0, 1, 0, 1, 0);
    chk("jalr_stall2", o_stall, 1);
    step(1, 7, 0, 1, 0, 0, 1, 0, 1, 0);
    chk("jalr_issue", o_stall, 0);

    // taken branch -> flush for FC cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("br_flush1", o_flush, 1);
    step(1, 1, 2, 1, 1, 8, 1, 0, 0, 0);
    chk("br_flush2", o_flush, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_flush_end", o_flush, 0);

    // add x3 ; add x3 ; sub x4,x3,x3 -> MEM beats WB
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    step(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
    chk("mem_fwd_a", fwd_a_sel, 1);
    chk("mem_fwd_b", fwd_b_sel, 1);

    // lw x0 ; add using x0 -> nothing
    step(1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
    chk("x0_no_stall", o_stall, 0);
    chk("x0_fwd_a", fwd_a_sel, 0);

    // load-use coincident with taken branch -> flush wins
    step(1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
    chk("lu_br_stall", o_stall, 0);
    chk("lu_br_flush", o_flush, 1);
    chk("lu_br_bubble", o_bub, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ex_bxx_taken = 0;
    #2;
    chk("pre_rst_flush", bxx_flush, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flush", bxx_flush, 0);
    chk("rst_mid_bubble", idex_bubble, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_flush", o_flush, 0);

    // randomized traffic on a small register window to provoke hits
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
